// File: rtl/fixed_audio_pkg.sv
// Shared fixed-point audio types and limits for the gain/saturation datapath.
// Samples and gains are signed Q values with FRACTIONAL_SIZE fraction bits.
package fixed_audio_pkg;

    localparam int unsigned OPERAND_SIZE    = 32;
    localparam int unsigned FRACTIONAL_SIZE = 12;

    typedef logic signed [OPERAND_SIZE-1:0]   sample_t;
    typedef logic signed [2*OPERAND_SIZE-1:0] product_t;

    localparam sample_t ONE        = sample_t'(1) << FRACTIONAL_SIZE;
    localparam sample_t SAMPLE_MAX = {1'b0, {(OPERAND_SIZE-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(OPERAND_SIZE-1){1'b0}}};

endpackage

// File: rtl/fixed_multiply.sv
// Signed fixed-point multiply: full double-width product rescaled by the
// fraction width (arithmetic shift, rounds toward minus infinity).
module fixed_multiply #(
    parameter int unsigned operand_size    = 32,
    parameter int unsigned fractional_size = 12
) (
    input  logic signed [operand_size-1:0]   a,
    input  logic signed [operand_size-1:0]   b,
    output logic signed [2*operand_size-1:0] product
);

    logic signed [2*operand_size-1:0] full;

    always_comb begin
        full    = $signed({{operand_size{a[operand_size-1]}}, a})
                * $signed({{operand_size{b[operand_size-1]}}, b});
        product = full >>> fractional_size;
    end

endmodule

// File: rtl/fixed_saturate.sv
// Clamps a double-width product to sample range and flags when clamping
// happened. Purely combinational.
module fixed_saturate
    import fixed_audio_pkg::*;
(
    input  product_t product,
    output sample_t  sample,
    output logic     clip
);

    always_comb begin
        sample = product[OPERAND_SIZE-1:0];
        clip   = 1'b0;
        if (product > product_t'(SAMPLE_MAX)) begin
            sample = SAMPLE_MAX;
            clip   = 1'b1;
        end else if (product < product_t'(SAMPLE_MIN)) begin
            sample = SAMPLE_MIN;
            clip   = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_gain_ramp.sv
// Streaming gain stage: sample * ramped gain, saturated back to sample width.
// Gain walks toward the software target by step_size per accepted sample.
module fixed_gain_ramp
    import fixed_audio_pkg::*;
#(
    parameter int unsigned fractional_size = 12,
    parameter int unsigned operand_size    = 32,
    parameter int unsigned step_size       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [operand_size-1:0] target_gain,
    input  logic                           target_valid,
    input  logic signed [operand_size-1:0] in_sample,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [operand_size-1:0] out_sample,
    output logic                           out_clip,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           ramp_active
);

    localparam logic signed [operand_size:0]   STEP_WIDE = (operand_size+1)'(step_size);
    localparam logic signed [operand_size-1:0] STEP_GAIN = operand_size'(step_size);

    logic signed [operand_size-1:0]   gain;
    logic signed [operand_size-1:0]   target;
    logic signed [operand_size-1:0]   gain_next;
    logic signed [operand_size-1:0]   target_next;
    logic signed [operand_size:0]     diff;
    logic signed [2*operand_size-1:0] mul_product;
    logic signed [2*operand_size-1:0] s1_product;
    logic                             s1_valid;
    logic                             s2_valid;
    logic                             adv2;
    logic                             accept;
    sample_t                          sat_sample;
    logic                             sat_clip;

    assign adv2      = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || adv2;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    fixed_multiply #(
        .operand_size   (operand_size),
        .fractional_size(fractional_size)
    ) u_mul (
        .a      (in_sample),
        .b      (gain),
        .product(mul_product)
    );

    fixed_saturate u_sat (
        .product(s1_product),
        .sample (sat_sample),
        .clip   (sat_clip)
    );

    // Step decision uses the target held before any same-cycle strobe.
    always_comb begin
        diff        = {target[operand_size-1], target} - {gain[operand_size-1], gain};
        gain_next   = gain;
        target_next = target_valid ? target_gain : target;
        if (accept) begin
            if (diff <= STEP_WIDE && diff >= -STEP_WIDE) begin
                gain_next = target;
            end else if (!diff[operand_size]) begin
                gain_next = gain + STEP_GAIN;
            end else begin
                gain_next = gain - STEP_GAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gain        <= '0;
            target      <= '0;
            ramp_active <= 1'b0;
            s1_valid    <= 1'b0;
            s1_product  <= '0;
            s2_valid    <= 1'b0;
            out_sample  <= '0;
            out_clip    <= 1'b0;
        end else begin
            gain        <= gain_next;
            target      <= target_next;
            ramp_active <= (gain_next != target_next);
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_product <= mul_product;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_sample <= sat_sample;
                    out_clip   <= sat_clip;
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_gain_ramp.sv
// Bench for fixed_gain_ramp: directed tables/sequences plus randomized traffic
// checked against an arithmetic reference model and scoreboard.
module tb_fixed_gain_ramp;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] target_gain;
    logic               target_valid;
    logic signed [31:0] in_sample;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] out_sample;
    logic               out_clip;
    logic               out_valid;
    logic               out_ready;
    logic               ramp_active;

    int vectors     = 0;
    int miscompares = 0;

    fixed_gain_ramp #(
        .fractional_size(12),
        .operand_size   (32),
        .step_size      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .target_gain (target_gain),
        .target_valid(target_valid),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_sample  (out_sample),
        .out_clip    (out_clip),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ramp_active (ramp_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] sample;
        logic signed [31:0] expect_out;
        logic               expect_clip;
    } vec_t;

    // Reference model state and captured outputs
    longint             m_gain;
    longint             m_target;
    logic [32:0]        exp_q[$];
    logic signed [31:0] got_q[$];
    logic               gotc_q[$];
    bit                 model_on = 0;
    bit                 held     = 0;
    logic signed [31:0] h_sample;
    logic               h_clip;

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [31:0] v);
        bit ok;
        ok        = 0;
        in_sample = v;
        in_valid  = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic set_target(input logic signed [31:0] v);
        target_gain  = v;
        target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (6) tick();
    endtask

    task automatic clear_got();
        got_q.delete();
        gotc_q.delete();
    endtask

    // Scoreboard/model: looks at what the next posedge will do.
    initial begin
        longint      p;
        longint      d;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("ramp_active", ramp_active, (m_gain != m_target));
                if (held) chk("stall_hold", {out_valid, out_clip, out_sample}, {1'b1, h_clip, h_sample});
            end
            if (rst) begin
                m_gain   = 0;
                m_target = 0;
                exp_q.delete();
                held     = 0;
                model_on = 1;
            end else if (model_on) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("scoreboard", {out_clip, out_sample}, e);
                    end
                    got_q.push_back(out_sample);
                    gotc_q.push_back(out_clip);
                end
                held     = out_valid && !out_ready;
                h_sample = out_sample;
                h_clip   = out_clip;
                if (in_valid && in_ready) begin
                    p = (longint'(in_sample) * m_gain) >>> 12;
                    if (p > 64'sd2147483647)       e = {1'b1, 32'h7FFF_FFFF};
                    else if (p < -64'sd2147483648) e = {1'b1, 32'h8000_0000};
                    else                           e = {1'b0, p[31:0]};
                    exp_q.push_back(e);
                    d = m_target - m_gain;
                    if (d <= 16 && d >= -16) m_gain = m_target;
                    else                     m_gain = m_gain + ((d > 0) ? 16 : -16);
                end
                if (target_valid) m_target = longint'(target_gain);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t sat_tab[9];
        longint g;

        sat_tab[0] = '{32'sh4000_0000, 32'sh7FFF_FFFF, 1'b1};
        sat_tab[1] = '{32'shC000_0000, 32'sh8000_0000, 1'b0};
        sat_tab[2] = '{32'sh3FFF_FFFF, 32'sh7FFF_FFFE, 1'b0};
        sat_tab[3] = '{32'sh4000_0001, 32'sh7FFF_FFFF, 1'b1};
        sat_tab[4] = '{32'shBFFF_FFFF, 32'sh8000_0000, 1'b1};
        sat_tab[5] = '{32'sd1000,      32'sd2000,      1'b0};
        sat_tab[6] = '{32'shFFFF_FFFD, 32'shFFFF_FFFA, 1'b0};
        sat_tab[7] = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 1'b1};
        sat_tab[8] = '{32'sh8000_0000, 32'sh8000_0000, 1'b1};

        rst = 1'b1; target_gain = '0; target_valid = 1'b0;
        in_sample = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_out_valid",  out_valid,   0);
        chk("reset_out_sample", out_sample,  0);
        chk("reset_out_clip",   out_clip,    0);
        chk("reset_ramp",       ramp_active, 0);
        chk("reset_in_ready",   in_ready,    1);

        // Ramp-up from 0 to unity on a constant stream
        set_target(32'sd4096);
        clear_got();
        for (int k = 0; k < 300; k++) begin
            send(32'sd1000);
            if (k == 254) chk("ramp_before_end", ramp_active, 1);
            if (k == 255) chk("ramp_after_end",  ramp_active, 0);
        end
        drain();
        chk("ramp_count", got_q.size(), 300);
        for (int k = 0; k < 300 && k < got_q.size(); k++) begin
            g = (16 * k < 4096) ? 16 * k : 4096;
            chk($sformatf("ramp_out_%0d", k), got_q[k], (1000 * g) >>> 12);
        end

        // Saturation at gain 2.0
        set_target(32'sd8192);
        for (int k = 0; k < 256; k++) send(32'sd0);
        drain();
        clear_got();
        for (int i = 0; i < 9; i++) send(sat_tab[i].sample);
        drain();
        chk("sat_count", got_q.size(), 9);
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            chk($sformatf("sat_out_%0d", i),  got_q[i],  sat_tab[i].expect_out);
            chk($sformatf("sat_clip_%0d", i), gotc_q[i], sat_tab[i].expect_clip);
        end

        // Backpressure at unity gain
        set_target(32'sd4096);
        for (int k = 0; k < 256; k++) send(32'sd0);
        drain();
        clear_got();
        begin
            bit saw_block;
            saw_block = 0;
            fork
                begin
                    for (int v = 1; v <= 10; v++) send(32'(v));
                end
                begin
                    repeat (3) tick();
                    out_ready = 1'b0;
                    for (int c = 0; c < 5; c++) begin
                        @(negedge clk);
                        if (!in_ready) saw_block = 1;
                        tick();
                    end
                    out_ready = 1'b1;
                end
            join
            chk("bp_in_ready_dropped", saw_block, 1);
        end
        drain();
        chk("bp_count", got_q.size(), 10);
        for (int i = 0; i < 10 && i < got_q.size(); i++) chk($sformatf("bp_out_%0d", i), got_q[i], i + 1);

        // Reversal mid-ramp, snap, then ramp to a negative target
        set_target(32'sd0);
        for (int k = 0; k < 131; k++) send(32'sd0);
        set_target(32'sd4096);
        set_target(32'sd1990);
        drain();
        clear_got();
        for (int k = 0; k < 3; k++) send(32'sd4096);
        set_target(-32'sd40);
        for (int k = 0; k < 130; k++) send(32'sd4096);
        drain();
        chk("rev_count", got_q.size(), 133);
        if (got_q.size() == 133) begin
            chk("rev_first", got_q[0], 2000);
            chk("snap_1",    got_q[1], 1990);
            chk("snap_2",    got_q[2], 1990);
            for (int j = 0; j < 130; j++) begin
                g = 1990 - 16 * j;
                if (g < -40) g = -40;
                chk($sformatf("neg_ramp_%0d", j), got_q[3 + j], g);
            end
        end

        // Strobe coincident with accept uses the old target for that step
        set_target(32'sd4096);
        for (int k = 0; k < 260; k++) send(32'sd0);
        set_target(32'sd8192);
        drain();
        clear_got();
        target_gain  = 32'sd0;
        target_valid = 1'b1;
        send(32'sd4096);
        target_valid = 1'b0;
        for (int k = 0; k < 3; k++) send(32'sd4096);
        drain();
        chk("coinc_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            chk("coinc_0", got_q[0], 4096);
            chk("coinc_1", got_q[1], 4112);
            chk("coinc_2", got_q[2], 4096);
            chk("coinc_3", got_q[3], 4080);
        end

        // Reset with both stages occupied drops the in-flight samples
        out_ready = 1'b0;
        send(32'sd7);
        send(32'sd8);
        chk("pre_reset_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset_out_valid", out_valid,   0);
        chk("mid_reset_in_ready",  in_ready,    1);
        chk("mid_reset_ramp",      ramp_active, 0);
        out_ready = 1'b1;
        clear_got();
        for (int k = 0; k < 3; k++) send(32'sd1000);
        drain();
        chk("post_reset_count", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) chk($sformatf("post_reset_out_%0d", i), got_q[i], 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_sample    = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 4000)) - 32'sd2000;
            out_ready    = ($urandom_range(0, 3) != 0);
            target_valid = ($urandom_range(0, 63) == 0);
            target_gain  = 32'($urandom_range(0, 24576)) - 32'sd12288;
            rst          = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        target_valid = 1'b0;
        drain();
        chk("random_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
